// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the 2-input gate BIST controller.
package gate_bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Expected F per input vector, bit index = {A,B}
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XNOR = 4'b1001;

    // Settle counter width; covers SETTLE_CYCLES up to 255
    localparam int CNT_W = 8;

endpackage

// File: rtl/bist_settle_timer.sv
// Settle timer: counts edges while enabled and flags the last edge of the
// settle window so the controller can sample F on that edge.
module bist_settle_timer
    import gate_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(SETTLE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Count up to the terminal value, then wrap to zero for the next vector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            if (tc) cnt <= '0;
            else    cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/gate_bist_ctrl.sv
// Built-in self-test controller for a 2-input combinational gate.
// Walks {A,B} through 00,01,10,11, holds each vector for SETTLE_CYCLES
// edges, samples F on the last edge and records mismatches.
//
//  state | meaning
//  IDLE  | after reset, waiting for start
//  RUN   | vectors being applied and checked; start ignored
//  DONE  | results held; start launches a fresh run
module gate_bist_ctrl
    import gate_bist_pkg::*;
#(
    parameter int         SETTLE_CYCLES = 10,
    parameter logic [3:0] TRUTH         = TT_XOR
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a_out,
    output logic       b_out,
    input  logic       f_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] fail_count,
    output logic [3:0] fail_mask
);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] idx;
    logic       tc;
    logic       accept;
    logic       sample;
    logic       mismatch;

    // A start outside RUN (IDLE or DONE) launches a run on this edge
    assign accept   = (state != RUN) && start;
    assign sample   = (state == RUN) && tc;
    assign mismatch = (f_in != TRUTH[idx]);

    bist_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (accept),
        .en   (state == RUN),
        .tc   (tc)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (sample && (idx == 2'd3)) state_nxt = DONE;
            DONE:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // Vector sequencing and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= 2'd0;
            a_out      <= 1'b0;
            b_out      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fail_count <= 3'd0;
            fail_mask  <= 4'd0;
        end else if (accept) begin
            idx            <= 2'd0;
            {a_out, b_out} <= 2'b00;
            busy           <= 1'b1;
            done           <= 1'b0;
            fail_count     <= 3'd0;
            fail_mask      <= 4'd0;
        end else if (sample) begin
            if (mismatch) begin
                fail_mask[idx] <= 1'b1;
                fail_count     <= fail_count + 3'd1;
            end
            if (idx == 2'd3) begin
                busy           <= 1'b0;
                done           <= 1'b1;
                {a_out, b_out} <= 2'b00;
            end else begin
                idx            <= idx + 2'd1;
                {a_out, b_out} <= idx + 2'd1;
            end
        end
    end

    // done is only set when busy clears, so pass can never overlap busy
    assign pass = done && (fail_count == 3'd0);

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Testbench for gate_bist_ctrl: three instances with different settle
// times and truth tables, each driven by a behavioural gate model.
module tb_gate_bist_ctrl;
    import gate_bist_pkg::*;

    localparam int NI = 3;
    // instance 0: XOR, 10 cycles; instance 1: XOR, 1 cycle; instance 2: AND, 4 cycles
    localparam logic [2:0][7:0] SCP = {8'd4, 8'd1, 8'd10};
    localparam logic [2:0][3:0] TTP = {TT_AND, TT_XOR, TT_XOR};

    logic       clk;
    logic       rst_n;
    logic       start      [NI];
    logic       a_out      [NI];
    logic       b_out      [NI];
    logic       f_in       [NI];
    logic       busy       [NI];
    logic       done       [NI];
    logic       pass       [NI];
    logic [2:0] fail_count [NI];
    logic [3:0] fail_mask  [NI];
    logic [3:0] gate_tt    [NI];

    int n_vec = 0;
    int n_err = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        gate_bist_ctrl #(
            .SETTLE_CYCLES(int'(SCP[g])),
            .TRUTH        (TTP[g])
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (start[g]),
            .a_out     (a_out[g]),
            .b_out     (b_out[g]),
            .f_in      (f_in[g]),
            .busy      (busy[g]),
            .done      (done[g]),
            .pass      (pass[g]),
            .fail_count(fail_count[g]),
            .fail_mask (fail_mask[g])
        );
        // Gate under test: output looked up from its own truth table
        assign f_in[g] = gate_tt[g][{a_out[g], b_out[g]}];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int         inst;
        logic [3:0] gtt;
        logic [3:0] mask;
        int         cnt;
        logic       pss;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input int n, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s inst%0d: got %0d expected %0d", name, n, act, exp);
        end
    endtask

    task automatic check_idle_zero(input int n);
        check("rst_ab",    n, {a_out[n], b_out[n]}, 0);
        check("rst_busy",  n, busy[n], 0);
        check("rst_done",  n, done[n], 0);
        check("rst_pass",  n, pass[n], 0);
        check("rst_count", n, fail_count[n], 0);
        check("rst_mask",  n, fail_mask[n], 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One run: vector order/timing every cycle, then results after 4*S edges.
    // With hold set, start stays high and the restart on the following edge is checked.
    task automatic run_check(input int n, input logic [3:0] gtt, input logic hold,
                             input logic [3:0] exp_mask, input int exp_cnt,
                             input logic exp_pass);
        int s;
        s = int'(SCP[n]);
        gate_tt[n] = gtt;
        @(negedge clk);
        start[n] = 1'b1;
        for (int k = 0; k < 4 * s; k++) begin
            @(negedge clk);
            if (!hold) start[n] = 1'b0;
            check("run_ab",   n, {a_out[n], b_out[n]}, k / s);
            check("run_busy", n, busy[n], 1);
            check("run_done", n, done[n], 0);
            check("run_pass", n, pass[n], 0);
        end
        @(negedge clk);
        check("end_done",  n, done[n], 1);
        check("end_busy",  n, busy[n], 0);
        check("end_ab",    n, {a_out[n], b_out[n]}, 0);
        check("end_mask",  n, fail_mask[n], exp_mask);
        check("end_count", n, fail_count[n], exp_cnt);
        check("end_pass",  n, pass[n], exp_pass);
        if (hold) begin
            @(negedge clk);
            start[n] = 1'b0;
            check("rs_done",  n, done[n], 0);
            check("rs_busy",  n, busy[n], 1);
            check("rs_mask",  n, fail_mask[n], 0);
            check("rs_count", n, fail_count[n], 0);
            check("rs_ab",    n, {a_out[n], b_out[n]}, 0);
        end else begin
            repeat (3) @(negedge clk);
            check("hold_done", n, done[n], 1);
            check("hold_mask", n, fail_mask[n], exp_mask);
        end
    endtask

    initial begin
        int         n;
        logic [3:0] gtt;
        logic [3:0] em;
        int         ec;

        tbl[0] = '{0, TT_XOR,  4'b0000, 0, 1'b1};
        tbl[1] = '{0, 4'b0000, 4'b0110, 2, 1'b0};
        tbl[2] = '{0, TT_XNOR, 4'b1111, 4, 1'b0};
        tbl[3] = '{2, TT_AND,  4'b0000, 0, 1'b1};
        tbl[4] = '{2, TT_OR,   4'b0110, 2, 1'b0};
        tbl[5] = '{1, TT_XOR,  4'b0000, 0, 1'b1};
        tbl[6] = '{1, TT_NAND, 4'b0001, 1, 1'b0};

        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            start[i]   = 1'b0;
            gate_tt[i] = TTP[i];
        end
        #1;
        for (int i = 0; i < NI; i++) check_idle_zero(i);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++)
            run_check(tbl[i].inst, tbl[i].gtt, 1'b0, tbl[i].mask, tbl[i].cnt, tbl[i].pss);

        // Reset 15 cycles into a run with a failing vector already recorded
        gate_tt[0] = 4'b1111;
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (14) @(negedge clk);
        check("pre_rst_mask", 0, fail_mask[0], 4'b0001);
        check("pre_rst_ab",   0, {a_out[0], b_out[0]}, 1);
        rst_n = 1'b0;
        #1;
        check_idle_zero(0);
        @(negedge clk);
        rst_n = 1'b1;
        run_check(0, TT_XOR, 1'b0, 4'b0000, 0, 1'b1);

        // start held high through a failing run: restarts right after done
        run_check(0, 4'b0000, 1'b1, 4'b0110, 2, 1'b0);
        do_reset();
        run_check(1, TT_XOR, 1'b1, 4'b0000, 0, 1'b1);
        do_reset();

        // Random gates against the per-vector truth-table model
        for (int r = 0; r < 12; r++) begin
            n   = int'($urandom_range(0, NI - 1));
            gtt = 4'($urandom_range(0, 15));
            em  = 4'b0000;
            ec  = 0;
            for (int v = 0; v < 4; v++) begin
                if (gtt[v] != TTP[n][v]) begin
                    em[v] = 1'b1;
                    ec    = ec + 1;
                end
            end
            run_check(n, gtt, 1'b0, em, ec, ec == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
